montgomery_encode: RTL

Converts a standard-domain coefficient into the Montgomery domain, y = a·2^K mod Q, so it can enter the Montgomery arithmetic datapath that `montgomery_reduce` leaves. It is the inverse-direction companion of the reducer: reduce strips the R = 2^K factor, encode applies it. It uses iterative modular doubling, one bit per cycle, with no multiplier. It accepts one coefficient at a time through a ready/enable handshake and pulses valid with the result.

---
 rtl/montgomery_encode.sv | 96 +++++++++
 1 files changed

// File: rtl/montgomery_encode.sv
// montgomery_encode: converts a standard-domain coefficient into the
// Montgomery domain, y = a * 2^K mod Q, by K rounds of modular doubling
// after an initial subtractive normalisation of inputs >= Q.
module montgomery_encode #(
  parameter int Q = 3329,
  parameter int W = 15,
  parameter int K = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] a,
  output logic         ready,
  output logic [W-1:0] y,
  output logic         valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [W-1:0] Q_N    = W'(Q);
  localparam logic [W:0]   Q_X    = (W + 1)'(Q);
  localparam logic [5:0]   K_LAST = 6'(K - 1);

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   r_y;
  logic [5:0]     r_cnt;

  logic [W:0]     w_t;
  logic           w_t_ge;
  logic [W-1:0]   w_dbl;
  logic           w_acc_ge;
  logic [W-1:0]   w_norm;
  logic           w_last;

  // Doubling step: acc < Q guarantees t < 2Q, so one conditional subtract
  // brings the result back into [0, Q) and it always fits in W bits.
  assign w_t      = {r_acc, 1'b0};
  assign w_t_ge   = (w_t >= Q_X);
  assign w_dbl    = w_t_ge ? W'(w_t - Q_X) : w_t[W-1:0];
  assign w_acc_ge = (r_acc >= Q_N);
  assign w_norm   = r_acc - Q_N;
  assign w_last   = (r_cnt == K_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (en) w_next = NORM;
      NORM:    if (!w_acc_ge) w_next = DBL;
      DBL:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: accumulator, doubling counter and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_y   <= '0;
    end else begin
      case (r_state)
        IDLE: if (en) r_acc <= a;
        NORM: begin
          if (w_acc_ge) r_acc <= w_norm;
          else          r_cnt <= '0;
        end
        DBL: begin
          r_acc <= w_dbl;
          r_cnt <= r_cnt + 6'd1;
          if (w_last) r_y <= w_dbl;
        end
        default: ;
      endcase
    end
  end

  assign ready = (r_state == IDLE);
  assign valid = (r_state == DONE);
  assign y     = r_y;

endmodule
